// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 set-2 scancode decoder for two-player game controls.
// Tracks E0/F0 prefixes with a small FSM, keeps held-key bits for player 1
// (WASD + Space) and player 2 (arrows + Enter), emits bomb-press pulses and
// drops stale prefixes after TIMEOUT_CYCLES idle clocks.
// Optional build macro PAUSE_KEY_EN adds a 'pause' output toggled by Esc.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [4:0] p1_keys,
    output logic [4:0] p2_keys,
    output logic       p1_bomb_pulse,
    output logic       p2_bomb_pulse
`ifdef PAUSE_KEY_EN
    ,
    output logic       pause
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    p1_keys_q, p1_keys_d;
    logic [4:0]    p2_keys_q, p2_keys_d;
    logic          p1_pulse_q, p1_pulse_d;
    logic          p2_pulse_q, p2_pulse_d;
    logic          dec_s;
    logic          ext_s;
    logic          brk_s;
`ifdef PAUSE_KEY_EN
    logic          pause_q, pause_d;
    logic          esc_held_q, esc_held_d;
`endif

    // Prefix FSM next-state and idle timeout; a byte always wins over an expiring timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_s   = 1'b0;
        ext_s   = 1'b0;
        brk_s   = 1'b0;
        if (data_valid) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (data_in == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (data_in == 8'hF0) begin
                        state_d = ST_BRK;
                    end else begin
                        dec_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (data_in == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (data_in == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        dec_s   = 1'b1;
                        ext_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (data_in == 8'hE0) begin
                        state_d = ST_EXT_BRK;
                    end else if (data_in == 8'hF0) begin
                        state_d = ST_BRK;
                    end else begin
                        dec_s   = 1'b1;
                        brk_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if ((data_in == 8'hE0) || (data_in == 8'hF0)) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        dec_s   = 1'b1;
                        ext_s   = 1'b1;
                        brk_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q >= TMO_LIMIT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Key map: make sets a bit, break clears it; bomb pulses fire only on a 0->1 edge.
    always_comb begin
        p1_keys_d  = p1_keys_q;
        p2_keys_d  = p2_keys_q;
        p1_pulse_d = 1'b0;
        p2_pulse_d = 1'b0;
`ifdef PAUSE_KEY_EN
        pause_d    = pause_q;
        esc_held_d = esc_held_q;
`endif
        if (dec_s && !ext_s) begin
            case (data_in)
                8'h1D: p1_keys_d[0] = !brk_s;
                8'h1B: p1_keys_d[1] = !brk_s;
                8'h1C: p1_keys_d[2] = !brk_s;
                8'h23: p1_keys_d[3] = !brk_s;
                8'h29: begin
                    p1_keys_d[4] = !brk_s;
                    p1_pulse_d   = !brk_s && !p1_keys_q[4];
                end
                8'h5A: begin
                    p2_keys_d[4] = !brk_s;
                    p2_pulse_d   = !brk_s && !p2_keys_q[4];
                end
`ifdef PAUSE_KEY_EN
                8'h76: begin
                    if (brk_s) begin
                        esc_held_d = 1'b0;
                    end else begin
                        // Only the first press of a hold toggles; typematic repeats are ignored.
                        if (!esc_held_q) begin
                            pause_d = !pause_q;
                        end else begin
                            pause_d = pause_q;
                        end
                        esc_held_d = 1'b1;
                    end
                end
`endif
                default: begin
                    p1_keys_d = p1_keys_q;
                end
            endcase
        end else if (dec_s && ext_s) begin
            case (data_in)
                8'h75:   p2_keys_d[0] = !brk_s;
                8'h72:   p2_keys_d[1] = !brk_s;
                8'h6B:   p2_keys_d[2] = !brk_s;
                8'h74:   p2_keys_d[3] = !brk_s;
                default: p2_keys_d = p2_keys_q;
            endcase
        end else begin
            p1_keys_d = p1_keys_q;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            p1_keys_q  <= 5'b0;
            p2_keys_q  <= 5'b0;
            p1_pulse_q <= 1'b0;
            p2_pulse_q <= 1'b0;
`ifdef PAUSE_KEY_EN
            pause_q    <= 1'b0;
            esc_held_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_keys_q  <= p1_keys_d;
            p2_keys_q  <= p2_keys_d;
            p1_pulse_q <= p1_pulse_d;
            p2_pulse_q <= p2_pulse_d;
`ifdef PAUSE_KEY_EN
            pause_q    <= pause_d;
            esc_held_q <= esc_held_d;
`endif
        end
    end

    assign p1_keys       = p1_keys_q;
    assign p2_keys       = p2_keys_q;
    assign p1_bomb_pulse = p1_pulse_q;
    assign p2_bomb_pulse = p2_pulse_q;
`ifdef PAUSE_KEY_EN
    assign pause         = pause_q;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: expected key state is queued with each
// byte and compared one cycle later when the registered outputs update.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;
    logic       p1_bomb_pulse;
    logic       p2_bomb_pulse;
    logic       pause_s;

    int tests = 0;
    int fails = 0;
    int p1_pc = 0;
    int p2_pc = 0;
    logic exp_pause = 1'b0;

    typedef struct {
        string      tag;
        logic [4:0] p1;
        logic [4:0] p2;
        logic       p1p;
        logic       p2p;
        logic       pz;
    } exp_t;

    exp_t sb[$];

    ps2_key_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .p1_keys       (p1_keys),
        .p2_keys       (p2_keys),
        .p1_bomb_pulse (p1_bomb_pulse),
        .p2_bomb_pulse (p2_bomb_pulse)
`ifdef PAUSE_KEY_EN
        ,
        .pause         (pause_s)
`endif
    );

`ifndef PAUSE_KEY_EN
    assign pause_s = 1'b0;
`endif

    always #5 clk = ~clk;

    // Count pulse-high cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (p1_bomb_pulse) p1_pc <= p1_pc + 1;
        if (p2_bomb_pulse) p2_pc <= p2_pc + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [7:0] b,
                        input logic [4:0] e1, input logic [4:0] e2,
                        input logic ep1, input logic ep2);
        exp_t e;
        exp_t got;
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        e.tag = tag; e.p1 = e1; e.p2 = e2; e.p1p = ep1; e.p2p = ep2; e.pz = exp_pause;
        sb.push_back(e);
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'h00;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            got = sb.pop_front();
            check({got.tag, "_p1"}, 8'(p1_keys), 8'(got.p1));
            check({got.tag, "_p2"}, 8'(p2_keys), 8'(got.p2));
            check({got.tag, "_p1p"}, 8'(p1_bomb_pulse), 8'(got.p1p));
            check({got.tag, "_p2p"}, 8'(p2_bomb_pulse), 8'(got.p2p));
            check({got.tag, "_pause"}, 8'(pause_s), 8'(got.pz));
        end
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_p1", 8'(p1_keys), 8'h00);
        check("rst_p2", 8'(p2_keys), 8'h00);
        check("rst_pulses", 8'({p1_bomb_pulse, p2_bomb_pulse}), 8'h00);
        check("rst_pause", 8'(pause_s), 8'h00);

        // make / break of p1 up
        send("up_make", 8'h1D, 5'h01, 5'h00, 1'b0, 1'b0);
        send("up_f0",   8'hF0, 5'h01, 5'h00, 1'b0, 1'b0);
        send("up_brk",  8'h1D, 5'h00, 5'h00, 1'b0, 1'b0);

        // extended arrows for p2
        send("e0_a",    8'hE0, 5'h00, 5'h00, 1'b0, 1'b0);
        send("p2_up",   8'h75, 5'h00, 5'h01, 1'b0, 1'b0);
        send("e0_b",    8'hE0, 5'h00, 5'h01, 1'b0, 1'b0);
        send("p2_left", 8'h6B, 5'h00, 5'h05, 1'b0, 1'b0);
        send("e0_c",    8'hE0, 5'h00, 5'h05, 1'b0, 1'b0);
        send("f0_c",    8'hF0, 5'h00, 5'h05, 1'b0, 1'b0);
        send("p2_up_b", 8'h75, 5'h00, 5'h04, 1'b0, 1'b0);

        // bomb typematic and re-press
        base = p1_pc;
        send("bomb1",   8'h29, 5'h10, 5'h04, 1'b1, 1'b0);
        send("bomb_r1", 8'h29, 5'h10, 5'h04, 1'b0, 1'b0);
        send("bomb_r2", 8'h29, 5'h10, 5'h04, 1'b0, 1'b0);
        send("bomb_f0", 8'hF0, 5'h10, 5'h04, 1'b0, 1'b0);
        send("bomb_bk", 8'h29, 5'h00, 5'h04, 1'b0, 1'b0);
        send("bomb2",   8'h29, 5'h10, 5'h04, 1'b1, 1'b0);
        @(negedge clk);
        check("p1_pulse_count", 8'(p1_pc - base), 8'd2);
        check("bomb_held_end", 8'(p1_keys[4]), 8'h01);
        send("bomb_f0b", 8'hF0, 5'h10, 5'h04, 1'b0, 1'b0);
        send("bomb_bkb", 8'h29, 5'h00, 5'h04, 1'b0, 1'b0);
        send("e0_d",     8'hE0, 5'h00, 5'h04, 1'b0, 1'b0);
        send("f0_d",     8'hF0, 5'h00, 5'h04, 1'b0, 1'b0);
        send("p2_lbrk",  8'h6B, 5'h00, 5'h00, 1'b0, 1'b0);

        // stale E0 abandoned after timeout; 1C then decodes as non-extended left
        send("tmo_e0",  8'hE0, 5'h00, 5'h00, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        check("tmo_keys", 8'({p1_keys, 3'b0} | 8'(p2_keys)), 8'h00);
        send("tmo_1c",  8'h1C, 5'h04, 5'h00, 1'b0, 1'b0);

        // prefix still alive before the timeout
        send("pre_e0",  8'hE0, 5'h04, 5'h00, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        send("pre_74",  8'h74, 5'h04, 5'h08, 1'b0, 1'b0);
        send("r_e0",    8'hE0, 5'h04, 5'h08, 1'b0, 1'b0);
        send("r_f0",    8'hF0, 5'h04, 5'h08, 1'b0, 1'b0);
        send("r_74",    8'h74, 5'h04, 5'h00, 1'b0, 1'b0);

        // wrong-class codes and ignored bytes
        send("kp_e0",   8'hE0, 5'h04, 5'h00, 1'b0, 1'b0);
        send("kp_5a",   8'h5A, 5'h04, 5'h00, 1'b0, 1'b0);
        send("ent",     8'h5A, 5'h04, 5'h10, 1'b0, 1'b1);
        send("ent_f0",  8'hF0, 5'h04, 5'h10, 1'b0, 1'b0);
        send("ent_bk",  8'h5A, 5'h04, 5'h00, 1'b0, 1'b0);
        send("fs_e0",   8'hE0, 5'h04, 5'h00, 1'b0, 1'b0);
        send("fs_12",   8'h12, 5'h04, 5'h00, 1'b0, 1'b0);
        send("ign_fa",  8'hFA, 5'h04, 5'h00, 1'b0, 1'b0);
        send("ign_aa",  8'hAA, 5'h04, 5'h00, 1'b0, 1'b0);
        send("ign_ee",  8'hEE, 5'h04, 5'h00, 1'b0, 1'b0);
        send("nh_f0",   8'hF0, 5'h04, 5'h00, 1'b0, 1'b0);
        send("nh_1b",   8'h1B, 5'h04, 5'h00, 1'b0, 1'b0);

        // opposite directions held together
        send("op_1b",   8'h1B, 5'h06, 5'h00, 1'b0, 1'b0);
        send("op_1d",   8'h1D, 5'h07, 5'h00, 1'b0, 1'b0);
        send("op_e0a",  8'hE0, 5'h07, 5'h00, 1'b0, 1'b0);
        send("op_72",   8'h72, 5'h07, 5'h02, 1'b0, 1'b0);
        send("op_e0b",  8'hE0, 5'h07, 5'h02, 1'b0, 1'b0);
        send("op_75",   8'h75, 5'h07, 5'h03, 1'b0, 1'b0);
        send("cl_f0a",  8'hF0, 5'h07, 5'h03, 1'b0, 1'b0);
        send("cl_1b",   8'h1B, 5'h05, 5'h03, 1'b0, 1'b0);
        send("cl_f0b",  8'hF0, 5'h05, 5'h03, 1'b0, 1'b0);
        send("cl_1c",   8'h1C, 5'h01, 5'h03, 1'b0, 1'b0);
        send("cl_f0c",  8'hF0, 5'h01, 5'h03, 1'b0, 1'b0);
        send("cl_1d",   8'h1D, 5'h00, 5'h03, 1'b0, 1'b0);
        send("tol_f0",  8'hF0, 5'h00, 5'h03, 1'b0, 1'b0);
        send("tol_e0",  8'hE0, 5'h00, 5'h03, 1'b0, 1'b0);
        send("tol_72",  8'h72, 5'h00, 5'h01, 1'b0, 1'b0);
        send("cl_e0",   8'hE0, 5'h00, 5'h01, 1'b0, 1'b0);
        send("cl_f0d",  8'hF0, 5'h00, 5'h01, 1'b0, 1'b0);
        send("cl_75",   8'h75, 5'h00, 5'h00, 1'b0, 1'b0);

        // Esc handling
`ifdef PAUSE_KEY_EN
        exp_pause = 1'b1;
        send("esc1",    8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
        send("esc_rep", 8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
        send("esc_f0",  8'hF0, 5'h00, 5'h00, 1'b0, 1'b0);
        send("esc_bk",  8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
        exp_pause = 1'b0;
        send("esc2",    8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
        send("esc2_f0", 8'hF0, 5'h00, 5'h00, 1'b0, 1'b0);
        send("esc2_bk", 8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
`else
        send("esc_unm", 8'h76, 5'h00, 5'h00, 1'b0, 1'b0);
`endif

        // reset in the middle of a break sequence
        send("rs_1d",   8'h1D, 5'h01, 5'h00, 1'b0, 1'b0);
        send("rs_5a",   8'h5A, 5'h01, 5'h10, 1'b0, 1'b1);
        send("rs_f0",   8'hF0, 5'h01, 5'h10, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_p1", 8'(p1_keys), 8'h00);
        check("mrst_p2", 8'(p2_keys), 8'h00);
        check("mrst_pulses", 8'({p1_bomb_pulse, p2_bomb_pulse}), 8'h00);
        exp_pause = 1'b0;
        send("post_1d", 8'h1D, 5'h01, 5'h00, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
